multi_user_grant_access: RTL

MULTI_USER_GRANT_ACCESS -- requirements
Module: multi_user_grant_access

---
 rtl/user_grant_pkg.sv | 5 +
 rtl/grant_lockout_ctrl.sv | 36 +++
 rtl/multi_user_grant_access.sv | 69 ++++++
 3 files changed

// File: rtl/user_grant_pkg.sv
// user_grant_pkg: shared op and lockout state encodings for the grant-access block
package user_grant_pkg;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_SET_OWNER, OP_RSVD} op_e;
  typedef enum logic {ST_OPEN, ST_LOCKED} state_e;
endpackage

// File: rtl/grant_lockout_ctrl.sv
// grant_lockout_ctrl: counts consecutive denials and holds a timed lockout
module grant_lockout_ctrl
  import user_grant_pkg::*;
#(
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_seen,
  input  logic granted,
  output logic locked
);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  state_e state;
  logic [FW-1:0] fail_cnt;
  logic [TW-1:0] lock_timer;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OPEN;
      fail_cnt   <= '0;
      lock_timer <= '0;
    end else if (state == ST_OPEN) begin
      if (req_seen && granted) fail_cnt <= '0;
      else if (req_seen && fail_cnt == FW'(MAX_FAIL - 1)) begin
        state      <= ST_LOCKED;
        lock_timer <= TW'(LOCK_CYCLES - 1);
        fail_cnt   <= '0;
      end else if (req_seen) fail_cnt <= fail_cnt + 1'b1;
    end else if (lock_timer == '0) state <= ST_OPEN;
    else lock_timer <= lock_timer - 1'b1;
  end
  // Current state, used combinationally by the grant decision of this cycle
  assign locked = (state == ST_LOCKED);
endmodule

// File: rtl/multi_user_grant_access.sv
// multi_user_grant_access: owner/admin-checked access to a small protected store
// with registered one-cycle responses and denial-triggered lockout.
module multi_user_grant_access
  import user_grant_pkg::*;
#(
  parameter int               DATA_W      = 8,
  parameter int               ID_W        = 3,
  parameter int               DEPTH       = 4,
  parameter logic [ID_W-1:0]  ADMIN_ID    = ID_W'(3'b100),
  parameter int               MAX_FAIL    = 3,
  parameter int               LOCK_CYCLES = 8,
  localparam int              AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [AW-1:0]     req_addr,
  input  logic [ID_W-1:0]   usr_id,
  input  logic [DATA_W-1:0] data_in,
  output logic              rsp_valid,
  output logic              rsp_grant,
  output logic [DATA_W-1:0] data_out,
  output logic              locked
);
  op_e op;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ID_W-1:0] owner_q [DEPTH];
  logic [AW-1:0] idx;
  logic addr_ok, is_admin, is_owner, grant, lock_state;
  assign op = op_e'(req_op);
  always_comb begin
    addr_ok  = int'(req_addr) < DEPTH;
    idx      = addr_ok ? req_addr : '0;
    is_admin = usr_id == ADMIN_ID;
    is_owner = usr_id == owner_q[idx];
    grant    = req_valid && !lock_state && addr_ok &&
               ((op == OP_READ || op == OP_WRITE) ? (is_owner || is_admin)
                                                   : (op == OP_SET_OWNER && is_admin));
  end
  grant_lockout_ctrl #(.MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)) u_lockout (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_seen (req_valid),
    .granted  (grant),
    .locked   (lock_state)
  );
  // Denied and idle cycles drive zero data so nothing leaks out of the store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]  <= '0;
        owner_q[i] <= ADMIN_ID;
      end
      rsp_valid <= 1'b0;
      rsp_grant <= 1'b0;
      data_out  <= '0;
      locked    <= 1'b0;
    end else begin
      rsp_valid <= req_valid;
      rsp_grant <= grant;
      locked    <= lock_state;
      data_out  <= (grant && op == OP_READ) ? data_q[idx] :
                   (grant && op == OP_WRITE) ? data_in : '0;
      if (grant && op == OP_WRITE) data_q[idx] <= data_in;
      if (grant && op == OP_SET_OWNER) owner_q[idx] <= data_in[ID_W-1:0];
    end
  end
endmodule
